fetch_pc_unit: RTL and testbench

- Fetch-stage program counter and instruction-fetch controller for the MRV32 core.
- Consumes the branch unit's take-branch decision and resolved target, issues word fetches to instruction memory over a valid/ready request channel, and presents fetched instructions to decode over a valid/ready channel.
- Keeps one fetch outstanding at most. Squashes wrong-path fetches on redirect.

---
 rtl/fetch_pc_unit.sv | 97 +++++++++
 tb/tb_fetch_pc_unit.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC and instruction-fetch controller: one fetch in flight,
// a single-entry slot toward decode, and squashing of wrong-path fetches on redirect.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        br_take,
  input  logic [31:0] br_target,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_misalign
);

  logic [31:0] pc_q;
  logic [31:0] req_pc_q;
  logic        outstanding_q;
  logic        discard_q;
  logic        misalign_q;
  logic        slot_valid_q;
  logic [31:0] slot_pc_q;
  logic [31:0] slot_instr_q;

  logic slot_free;
  logic req_fire;
  logic rsp_live;
  logic slot_take;

  assign slot_free      = !slot_valid_q || if_ready;
  assign imem_req_valid = !rst && !br_take && !outstanding_q && slot_free;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  // Responses with nothing in flight are leftovers from before a reset.
  assign rsp_live       = imem_rsp_valid && outstanding_q;
  assign slot_take      = slot_valid_q && if_ready;

  assign if_valid    = slot_valid_q;
  assign if_pc       = slot_pc_q;
  assign if_instr    = slot_instr_q;
  assign if_misalign = misalign_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      req_pc_q      <= RESET_PC;
      outstanding_q <= 1'b0;
      discard_q     <= 1'b0;
      misalign_q    <= 1'b0;
      slot_valid_q  <= 1'b0;
      slot_pc_q     <= 32'h0;
      slot_instr_q  <= 32'h0;
    end else begin
      misalign_q <= 1'b0;
      if (br_take) begin
        pc_q         <= {br_target[31:2], 2'b00};
        slot_valid_q <= 1'b0;
        misalign_q   <= |br_target[1:0];
        if (outstanding_q) begin
          if (imem_rsp_valid) begin
            outstanding_q <= 1'b0;
            discard_q     <= 1'b0;
          end else begin
            discard_q <= 1'b1;
          end
        end
      end else begin
        if (req_fire) begin
          req_pc_q      <= pc_q;
          pc_q          <= pc_q + 32'd4;
          outstanding_q <= 1'b1;
        end
        if (slot_take) begin
          slot_valid_q <= 1'b0;
        end
        // A returning word may refill the slot in the same cycle it drains.
        if (rsp_live) begin
          outstanding_q <= 1'b0;
          if (discard_q) begin
            discard_q <= 1'b0;
          end else begin
            slot_valid_q <= 1'b1;
            slot_pc_q    <= req_pc_q;
            slot_instr_q <= imem_rsp_data;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: a queue-based reference model checked every
// cycle, plus literal expectations on accepted addresses and delivered PCs.
module tb_fetch_pc_unit;

  logic        clk;
  logic        rst;
  logic        br_take;
  logic [31:0] br_target;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_misalign;

  logic        u2_req_valid;
  logic [31:0] u2_req_addr;
  logic        u2_if_valid;
  logic [31:0] u2_if_pc;
  logic [31:0] u2_if_instr;
  logic        u2_if_misalign;

  fetch_pc_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .br_take(br_take), .br_target(br_target),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .if_valid(if_valid), .if_ready(if_ready),
    .if_pc(if_pc), .if_instr(if_instr), .if_misalign(if_misalign)
  );

  // Second instance only pins the reset PC and address wrap.
  fetch_pc_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst), .br_take(br_take), .br_target(br_target),
    .imem_req_valid(u2_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(u2_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .if_valid(u2_if_valid), .if_ready(if_ready),
    .if_pc(u2_if_pc), .if_instr(u2_if_instr), .if_misalign(u2_if_misalign)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  bit check_en = 0;
  int cyc = 0;
  int lat = 1;
  int rsp_wait = 0;
  logic [31:0] rsp_addr = 32'h0;
  logic [31:0] acc_addr[$];
  int          acc_cyc[$];
  logic [31:0] deliv_pc[$];

  // Reference model: the PC, the single in-flight fetch and the decode slot.
  logic [31:0] m_pc;
  logic [31:0] m_inflight[$];
  bit          m_squashed;
  logic [63:0] m_slot[$];
  bit          m_mis;

  function automatic logic [31:0] instr_of(logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  function automatic bit exp_req_valid();
    return !rst && !br_take && (m_inflight.size() == 0) &&
           ((m_slot.size() == 0) || if_ready);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model
    bit fire;
    bit rsp;
    bit cons;
    logic [31:0] fpc;
    if (rst) begin
      m_pc = 32'h0000_0000;
      m_inflight.delete();
      m_squashed = 0;
      m_slot.delete();
      m_mis = 0;
    end else begin
      fire = exp_req_valid() && imem_req_ready;
      rsp  = imem_rsp_valid && (m_inflight.size() != 0);
      cons = (m_slot.size() != 0) && if_ready;
      m_mis = 0;
      if (br_take) begin
        m_pc = br_target & ~32'h3;
        m_slot.delete();
        m_mis = (br_target % 4) != 0;
        if (rsp) begin
          m_inflight.delete();
          m_squashed = 0;
        end else if (m_inflight.size() != 0) begin
          m_squashed = 1;
        end
      end else begin
        if (fire) begin
          m_inflight.push_back(m_pc);
          m_pc = m_pc + 4;
        end
        if (cons) m_slot.delete();
        if (rsp) begin
          fpc = m_inflight.pop_front();
          if (m_squashed) m_squashed = 0;
          else m_slot.push_back({fpc, imem_rsp_data});
        end
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_req_valid()});
      if (!rst) chk("req_addr", imem_req_addr, m_pc);
      chk("if_valid", {31'b0, if_valid}, {31'b0, m_slot.size() != 0});
      if (m_slot.size() != 0) begin
        chk("if_pc", if_pc, m_slot[0][63:32]);
        chk("if_instr", if_instr, m_slot[0][31:0]);
      end
      chk("if_misalign", {31'b0, if_misalign}, {31'b0, m_mis});
      if (if_valid && if_ready) deliv_pc.push_back(if_pc);
    end
  end

  // One clock: sample handshake mid-cycle, then advance and drive the memory response.
  task automatic tick();
    logic f;
    logic [31:0] a;
    @(negedge clk);
    f = imem_req_valid && imem_req_ready;
    a = imem_req_addr;
    @(posedge clk);
    #1;
    cyc++;
    imem_rsp_valid = 1'b0;
    if (f) begin
      acc_addr.push_back(a);
      acc_cyc.push_back(cyc);
      rsp_wait = lat;
      rsp_addr = a;
    end
    if (rsp_wait > 0) begin
      rsp_wait--;
      if (rsp_wait == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = instr_of(rsp_addr);
      end
    end
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rsp_wait = 0;
    br_take = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic clear_logs();
    acc_addr.delete();
    acc_cyc.delete();
    deliv_pc.delete();
  endtask

  initial begin
    rst = 1'b1;
    br_take = 1'b0;
    br_target = 32'h0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'h0;
    if_ready = 1'b1;

    // Reset state
    ticks(3);
    chk("rst_if_valid", {31'b0, if_valid}, 32'h0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_instr", if_instr, 32'h0);
    chk("rst_if_misalign", {31'b0, if_misalign}, 32'h0);
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    check_en = 1;

    // Streaming at one instruction per two cycles
    clear_logs();
    rst = 1'b0;
    ticks(9);
    chk("t1_acc_n", acc_addr.size() >= 3, 32'h1);
    chk("t1_deliv_n", deliv_pc.size() >= 3, 32'h1);
    if (acc_addr.size() >= 3 && deliv_pc.size() >= 3) begin
      chk("t1_acc0", acc_addr[0], 32'h0);
      chk("t1_acc1", acc_addr[1], 32'h4);
      chk("t1_acc2", acc_addr[2], 32'h8);
      chk("t1_gap", acc_cyc[1] - acc_cyc[0], 32'd2);
      chk("t1_dv0", deliv_pc[0], 32'h0);
      chk("t1_dv1", deliv_pc[1], 32'h4);
      chk("t1_dv2", deliv_pc[2], 32'h8);
    end

    // Decode stall with 0x4 in the slot
    do_reset();
    ticks(4);
    if_ready = 1'b0;
    chk("t2_pc_start", if_pc, 32'h4);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_hold_pc", if_pc, 32'h4);
      chk("t2_hold_instr", if_instr, instr_of(32'h4));
      chk("t2_hold_reqv", {31'b0, imem_req_valid}, 32'h0);
    end
    if_ready = 1'b1;
    #1;
    chk("t2_rel_reqv", {31'b0, imem_req_valid}, 32'h1);
    chk("t2_rel_addr", imem_req_addr, 32'h8);
    ticks(3);

    // Redirect while the 0x10 fetch is still pending
    do_reset();
    clear_logs();
    br_take = 1'b1; br_target = 32'h10;
    tick();
    br_take = 1'b0; lat = 3;
    tick();
    br_take = 1'b1; br_target = 32'h200; lat = 1;
    tick();
    br_take = 1'b0;
    ticks(7);
    chk("t3_acc_n", acc_addr.size() >= 2, 32'h1);
    chk("t3_dv_n", deliv_pc.size() >= 1, 32'h1);
    if (acc_addr.size() >= 2 && deliv_pc.size() >= 1) begin
      chk("t3_acc0", acc_addr[0], 32'h10);
      chk("t3_acc1", acc_addr[1], 32'h200);
      chk("t3_dv0", deliv_pc[0], 32'h200);
    end

    // Redirect in the same cycle as the 0x10 response
    do_reset();
    clear_logs();
    br_take = 1'b1; br_target = 32'h10; lat = 1;
    tick();
    br_take = 1'b0;
    tick();
    chk("t4_rsp_now", {31'b0, imem_rsp_valid}, 32'h1);
    br_take = 1'b1; br_target = 32'h200;
    tick();
    br_take = 1'b0;
    ticks(5);
    chk("t4_acc_n", acc_addr.size() >= 2, 32'h1);
    chk("t4_dv_n", deliv_pc.size() >= 1, 32'h1);
    if (acc_addr.size() >= 2 && deliv_pc.size() >= 1) begin
      chk("t4_acc0", acc_addr[0], 32'h10);
      chk("t4_acc1", acc_addr[1], 32'h200);
      chk("t4_dv0", deliv_pc[0], 32'h200);
    end

    // Misaligned redirect target
    clear_logs();
    br_take = 1'b1; br_target = 32'h103;
    tick();
    br_take = 1'b0;
    chk("t5_mis_on", {31'b0, if_misalign}, 32'h1);
    tick();
    chk("t5_mis_off", {31'b0, if_misalign}, 32'h0);
    ticks(4);
    chk("t5_acc_n", acc_addr.size() >= 1, 32'h1);
    if (acc_addr.size() >= 1) chk("t5_acc0", acc_addr[0], 32'h100);

    // Reset with a fetch in flight, stale response afterwards
    lat = 0;
    do_reset();
    tick();
    tick();
    rst = 1'b1;
    tick();
    tick();
    imem_req_ready = 1'b0;
    rst = 1'b0;
    #1;
    chk("t6_reqv", {31'b0, imem_req_valid}, 32'h1);
    chk("t6_addr", imem_req_addr, 32'h0);
    chk("t6_u2_addr", u2_req_addr, 32'hFFFF_FFFC);
    tick();
    tick();
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'hBAD0_BAD0;
    tick();
    chk("t6_stale", {31'b0, if_valid}, 32'h0);
    chk("t6_u2_reqv", {31'b0, u2_req_valid}, 32'h1);
    clear_logs();
    lat = 1;
    imem_req_ready = 1'b1;
    tick();
    chk("t6_u2_wrap", u2_req_addr, 32'h0);
    ticks(3);
    chk("t6_acc_n", acc_addr.size() >= 1, 32'h1);
    chk("t6_dv_n", deliv_pc.size() >= 1, 32'h1);
    if (acc_addr.size() >= 1 && deliv_pc.size() >= 1) begin
      chk("t6_acc0", acc_addr[0], 32'h0);
      chk("t6_dv0", deliv_pc[0], 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
